// File: rtl/pwm_capture.sv
// PWM frame capture: measures rise-to-rise period and high time, reports timeouts on static input.
// Optional glitch filter on the synchronized input is enabled by defining GLITCH_FILTER_EN.
module pwm_capture #(
   parameter int CNT_W       = 16,
   parameter int MAX_PERIOD  = 1023,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             level
);

   localparam logic [0:0]       IDLE    = 1'b0;
   localparam logic [0:0]       MEASURE = 1'b1;
   localparam logic [CNT_W-1:0] MAXP    = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   f;
   logic                   f_d;
   logic                   rise;
   logic [0:0]             state;
   logic [CNT_W-1:0]       pcnt;
   logic [CNT_W-1:0]       hcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sin};
      end
   end

   assign s = sync[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
   // f follows s only once s has disagreed with it for FILT_LEN cycles in a row
   localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   logic [FW-1:0] fcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         f    <= 1'b0;
         fcnt <= '0;
      end else if (s != f) begin
         if (fcnt == FW'(FILT_LEN - 1)) begin
            f    <= s;
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end else begin
         fcnt <= '0;
      end
   end
`else
   localparam int unused_filt_len = FILT_LEN;
   assign f = s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         f_d <= 1'b0;
      end else begin
         f_d <= f;
      end
   end

   assign rise = f & ~f_d;

   // A rise always wins over a coinciding timeout; the rise cycle itself counts as high
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pcnt      <= '0;
         hcnt      <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
         level     <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  pcnt  <= ONE;
                  hcnt  <= ONE;
                  state <= MEASURE;
               end else if (pcnt == MAXP) begin
                  timeout <= 1'b1;
                  level   <= f;
                  pcnt    <= '0;
               end else begin
                  pcnt <= pcnt + ONE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period    <= pcnt;
                  high_time <= hcnt;
                  valid     <= 1'b1;
                  pcnt      <= ONE;
                  hcnt      <= ONE;
               end else if (pcnt == MAXP) begin
                  timeout <= 1'b1;
                  level   <= f;
                  pcnt    <= '0;
                  hcnt    <= '0;
                  state   <= IDLE;
               end else begin
                  pcnt <= pcnt + ONE;
                  hcnt <= hcnt + CNT_W'(f);
               end
            end
            default: begin
               state <= IDLE;
               pcnt  <= '0;
               hcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: drives a precomputed sin waveform and compares every
// output on every cycle against an event-level reference model of the capture rules.
module tb_pwm_capture;

   localparam int CNT_W       = 16;
   localparam int MAX_PERIOD  = 1023;
   localparam int SYNC_STAGES = 2;
   localparam int FILT_LEN    = 3;

   logic             clk;
   logic             rst;
   logic             sin;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             timeout;
   logic             level;

   int assertCount;
   int failCount;

   bit w[$];
   int expValid[$];
   int expTimeout[$];
   int expLevel[$];
   int expPeriod[$];
   int expHigh[$];

   pwm_capture #(
      .CNT_W      (CNT_W),
      .MAX_PERIOD (MAX_PERIOD),
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sin      (sin),
      .period   (period),
      .high_time(high_time),
      .valid    (valid),
      .timeout  (timeout),
      .level    (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic appendPulse(input int per, input int hi);
      for (int i = 0; i < per; i++) w.push_back(i < hi);
   endtask

   task automatic appendLevel(input bit v, input int n);
      for (int i = 0; i < n; i++) w.push_back(v);
   endtask

   // Reference: find rises on the sampled stream, pair them into frames, and apply the
   // timeout deadline (MAX_PERIOD after reset or the last rise, MAX_PERIOD+1 after a timeout)
   task automatic buildModel();
      int x[$];
      int armed, last, deadline, curP, curH, curL, ev, et, prev, sum;
      int n;
      n = w.size();
      x = {};
      for (int j = 0; j < n; j++) x.push_back((j < SYNC_STAGES) ? 0 : int'(w[j - SYNC_STAGES]));
`ifdef GLITCH_FILTER_EN
      begin
         int fv, run;
         int fx[$];
         fv = 0;
         run = 0;
         fx = {};
         for (int j = 0; j < n; j++) begin
            fx.push_back(fv);
            if (x[j] != fv) begin
               run++;
               if (run == FILT_LEN) begin
                  fv = x[j];
                  run = 0;
               end
            end else begin
               run = 0;
            end
         end
         x = fx;
      end
`endif
      expValid = {};
      expTimeout = {};
      expLevel = {};
      expPeriod = {};
      expHigh = {};
      armed = 0;
      last = 0;
      deadline = MAX_PERIOD;
      curP = 0;
      curH = 0;
      curL = 0;
      for (int j = 0; j < n; j++) begin
         ev = 0;
         et = 0;
         prev = (j > 0) ? x[j - 1] : 0;
         if (x[j] == 1 && prev == 0) begin
            if (armed == 1) begin
               sum = 0;
               for (int i = last; i < j; i++) sum += x[i];
               ev = 1;
               curP = j - last;
               curH = sum;
            end
            armed = 1;
            last = j;
            deadline = j + MAX_PERIOD;
         end else if (j == deadline) begin
            et = 1;
            curL = x[j];
            armed = 0;
            deadline = j + 1 + MAX_PERIOD;
         end
         expValid.push_back(ev);
         expTimeout.push_back(et);
         expLevel.push_back(curL);
         expPeriod.push_back(curP);
         expHigh.push_back(curH);
      end
   endtask

   // Entered at a negedge with rst high; leaves with a one-cycle reset applied mid-frame
   task automatic applyStimulus();
      buildModel();
      rst = 1'b0;
      for (int k = 0; k < w.size(); k++) begin
         sin = w[k];
         @(negedge clk);
         checkOutput($sformatf("valid@%0d", k), 32'(valid), 32'(expValid[k]));
         checkOutput($sformatf("timeout@%0d", k), 32'(timeout), 32'(expTimeout[k]));
         checkOutput($sformatf("level@%0d", k), 32'(level), 32'(expLevel[k]));
         checkOutput($sformatf("period@%0d", k), 32'(period), 32'(expPeriod[k]));
         checkOutput($sformatf("high_time@%0d", k), 32'(high_time), 32'(expHigh[k]));
      end
      rst = 1'b1;
      sin = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("reset valid", 32'(valid), 32'd0);
      checkOutput("reset timeout", 32'(timeout), 32'd0);
      checkOutput("reset level", 32'(level), 32'd0);
      checkOutput("reset period", 32'(period), 32'd0);
      checkOutput("reset high_time", 32'(high_time), 32'd0);
      w = {};
   endtask

   initial begin
      int per;
      assertCount = 0;
      failCount = 0;
      rst = 1'b1;
      sin = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("initial valid", 32'(valid), 32'd0);
      checkOutput("initial period", 32'(period), 32'd0);

      // Looped-back PWM streams with duty changes and a truncated final frame
      for (int i = 0; i < 6; i++) appendPulse(256, 64);
      for (int i = 0; i < 3; i++) appendPulse(256, 255);
      for (int i = 0; i < 3; i++) appendPulse(256, 1);
      for (int i = 0; i < 8; i++) appendPulse(256, $urandom_range(0, 255));
      appendPulse(64 + $urandom_range(1, 150), 64);
      applyStimulus();

      // Static levels and rise spacings straddling MAX_PERIOD
      appendLevel(1'b0, 2500);
      appendLevel(1'b1, 2500);
      appendLevel(1'b0, 10);
      for (int i = 0; i < 2; i++) appendPulse(MAX_PERIOD, 10);
      for (int i = 0; i < 2; i++) appendPulse(MAX_PERIOD + 1, 10);
      for (int i = 0; i < 2; i++) appendPulse(MAX_PERIOD, 500);
      appendPulse(100, 40);
      applyStimulus();

      // Random frames, then a 1-cycle glitch inside the low phase of 256/64 frames
      for (int i = 0; i < 25; i++) begin
         per = $urandom_range(2, 1100);
         appendPulse(per, $urandom_range(1, per - 1));
      end
      for (int i = 0; i < 2; i++) appendPulse(256, 64);
      for (int i = 0; i < 2; i++) begin
         appendPulse(100, 64);
         appendPulse(156, 1);
      end
      for (int i = 0; i < 2; i++) appendPulse(256, 64);
      appendPulse(30, 20);
      applyStimulus();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
